// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcode constants, immediate-format enumeration,
// NOP encoding and small helpers used by decode and downstream stages.
package decode_stage_pkg;

   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;
   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_OPIMM   = 7'b0010011;
   localparam logic [6:0] OP_OP      = 7'b0110011;
   localparam logic [6:0] OP_MISCMEM = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

   // ADDI x0,x0,0
   localparam logic [31:0] NOP_INST = 32'h00000013;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_BAD
   } imm_fmt_e;

   // Instruction format implied by the major opcode; FMT_BAD for unsupported opcodes
   function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
      imm_fmt_e f;
      case (op)
         OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM, OP_MISCMEM: f = FMT_I;
         OP_STORE:                                          f = FMT_S;
         OP_BRANCH:                                         f = FMT_B;
         OP_LUI, OP_AUIPC:                                  f = FMT_U;
         OP_JAL:                                            f = FMT_J;
         OP_OP:                                             f = FMT_R;
         default:                                           f = FMT_BAD;
      endcase
      return f;
   endfunction

   // 32-bit sign-extended immediate; callers widen it to the datapath width
   function automatic logic [31:0] imm32_of(input imm_fmt_e fmt, input logic [31:0] inst);
      logic [31:0] imm;
      case (fmt)
         FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
         FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         FMT_U:   imm = {inst[31:12], 12'b0};
         FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

   // Register index exists in a file of nreg entries (x0 included)
   function automatic logic idx_lt(input logic [4:0] idx, input int unsigned nreg);
      return 32'(idx) < nreg;
   endfunction

   // Register index refers to a real, writable entry
   function automatic logic idx_ok(input logic [4:0] idx, input int unsigned nreg);
      return (idx != '0) && idx_lt(idx, nreg);
   endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Architectural register file: one write port, three combinational read
// ports (rs1, rs2, debug). x0 and out-of-range indices read as zero.
module regfile
   import decode_stage_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            W_EN,
   input  logic [4:0]      W_REG,
   input  logic [XLEN-1:0] W_DATA,
   input  logic [4:0]      R1_REG,
   output logic [XLEN-1:0] R1_DATA,
   input  logic [4:0]      R2_REG,
   output logic [XLEN-1:0] R2_DATA,
   input  logic [4:0]      R3_REG,
   output logic [XLEN-1:0] R3_DATA
);

   localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

   // Entry 0 is never written and never read; it only keeps indexing simple
   logic [XLEN-1:0] mem [NREG];

   // Write port; reset clears every entry and overrides a pending write
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (W_EN && idx_ok(W_REG, NREG)) begin
         mem[W_REG[AW-1:0]] <= W_DATA;
      end
   end

   // Read ports, masked to zero for x0 and indices beyond the file
   always_comb begin
      R1_DATA = '0;
      R2_DATA = '0;
      R3_DATA = '0;
      if (idx_ok(R1_REG, NREG)) R1_DATA = mem[R1_REG[AW-1:0]];
      if (idx_ok(R2_REG, NREG)) R2_DATA = mem[R2_REG[AW-1:0]];
      if (idx_ok(R3_REG, NREG)) R3_DATA = mem[R3_REG[AW-1:0]];
   end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: fetch/decode pipeline register, combinational field and
// immediate decode, illegal-instruction detection and register-file read
// with optional write-back forwarding.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREG   = 32,
   parameter int unsigned BYPASS = 1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            STALL,
   input  logic            FLUSH,
   input  logic [XLEN-1:0] I_PC,
   input  logic [31:0]     I_INST,
   input  logic            I_VALID,
   input  logic            W_VALID,
   input  logic [4:0]      W_REG,
   input  logic [XLEN-1:0] W_DATA,
   output logic [XLEN-1:0] D_PC,
   output logic [31:0]     D_INST,
   output logic            D_VALID,
   output logic [6:0]      D_OPCODE,
   output logic [2:0]      D_FUNCT3,
   output logic [6:0]      D_FUNCT7,
   output logic [XLEN-1:0] D_IMM,
   output logic [4:0]      D_REG_D,
   output logic [4:0]      D_REG_S1,
   output logic [XLEN-1:0] D_REG_S1_V,
   output logic [4:0]      D_REG_S2,
   output logic [XLEN-1:0] D_REG_S2_V,
   output logic            D_ILLEGAL,
   input  logic [4:0]      DBG_SEL,
   output logic [XLEN-1:0] DBG_V
);

   logic [XLEN-1:0]   pc_q;
   logic [31:0]       inst_q;
   logic              valid_q;

   imm_fmt_e          fmt;
   logic signed [31:0] imm32;
   logic              uses_rd;
   logic              uses_rs1;
   logic              uses_rs2;
   logic              idx_bad;

   logic [XLEN-1:0]   rf_s1;
   logic [XLEN-1:0]   rf_s2;
   logic              fwd_s1;
   logic              fwd_s2;

   // Pipeline register: reset, then flush (beats stall), then hold or capture
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= 1'b0;
         inst_q  <= NOP_INST;
         pc_q    <= '0;
      end else if (FLUSH) begin
         valid_q <= 1'b0;
         inst_q  <= NOP_INST;
         pc_q    <= I_PC;
      end else if (!STALL) begin
         valid_q <= I_VALID;
         inst_q  <= I_INST;
         pc_q    <= I_PC;
      end
   end

   assign D_PC     = pc_q;
   assign D_INST   = inst_q;
   assign D_VALID  = valid_q;
   assign D_OPCODE = inst_q[6:0];
   assign D_FUNCT3 = inst_q[14:12];
   assign D_FUNCT7 = inst_q[31:25];
   assign D_REG_D  = inst_q[11:7];
   assign D_REG_S1 = inst_q[19:15];
   assign D_REG_S2 = inst_q[24:20];

   // Format classification and which register fields the format actually uses
   always_comb begin
      fmt      = imm_fmt(inst_q[6:0]);
      imm32    = imm32_of(fmt, inst_q);
      uses_rd  = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
      uses_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
      uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
   end

   // Size cast of a signed value sign-extends to the datapath width
   assign D_IMM = XLEN'(imm32);

   // Illegal: unsupported opcode or a used index outside the register file
   always_comb begin
      idx_bad   = (uses_rd  && !idx_lt(inst_q[11:7],  NREG)) ||
                  (uses_rs1 && !idx_lt(inst_q[19:15], NREG)) ||
                  (uses_rs2 && !idx_lt(inst_q[24:20], NREG));
      D_ILLEGAL = valid_q && ((fmt == FMT_BAD) || idx_bad);
   end

   regfile #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_regfile (
      .CLK     (CLK),
      .RST     (RST),
      .W_EN    (W_VALID),
      .W_REG   (W_REG),
      .W_DATA  (W_DATA),
      .R1_REG  (inst_q[19:15]),
      .R1_DATA (rf_s1),
      .R2_REG  (inst_q[24:20]),
      .R2_DATA (rf_s2),
      .R3_REG  (DBG_SEL),
      .R3_DATA (DBG_V)
   );

   // Write-back forwarding onto the source read ports
   always_comb begin
      fwd_s1     = (BYPASS != 0) && W_VALID && (W_REG == inst_q[19:15]) && idx_ok(inst_q[19:15], NREG);
      fwd_s2     = (BYPASS != 0) && W_VALID && (W_REG == inst_q[24:20]) && idx_ok(inst_q[24:20], NREG);
      D_REG_S1_V = fwd_s1 ? W_DATA : rf_s1;
      D_REG_S2_V = fwd_s2 ? W_DATA : rf_s2;
   end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (XLEN=32/NREG=32/BYPASS=1 and
// XLEN=64/NREG=16/BYPASS=0) share stimulus and are compared every cycle
// against a behavioural model, plus vector table and directed sequences.
module tb_decode_stage;

   logic        CLK;
   logic        RST, STALL, FLUSH, I_VALID, W_VALID;
   logic [63:0] I_PC, W_DATA;
   logic [31:0] I_INST;
   logic [4:0]  W_REG, DBG_SEL;

   logic [31:0] a_pc, a_imm, a_s1v, a_s2v, a_dbg, a_inst;
   logic        a_valid, a_ill;
   logic [6:0]  a_op, a_f7;
   logic [2:0]  a_f3;
   logic [4:0]  a_rd, a_rs1, a_rs2;

   logic [63:0] b_pc, b_imm, b_s1v, b_s2v, b_dbg;
   logic [31:0] b_inst;
   logic        b_valid, b_ill;
   logic [6:0]  b_op, b_f7;
   logic [2:0]  b_f3;
   logic [4:0]  b_rd, b_rs1, b_rs2;

   decode_stage #(.XLEN(32), .NREG(32), .BYPASS(1)) dut_a (
      .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
      .I_PC(I_PC[31:0]), .I_INST(I_INST), .I_VALID(I_VALID),
      .W_VALID(W_VALID), .W_REG(W_REG), .W_DATA(W_DATA[31:0]),
      .D_PC(a_pc), .D_INST(a_inst), .D_VALID(a_valid), .D_OPCODE(a_op),
      .D_FUNCT3(a_f3), .D_FUNCT7(a_f7), .D_IMM(a_imm), .D_REG_D(a_rd),
      .D_REG_S1(a_rs1), .D_REG_S1_V(a_s1v), .D_REG_S2(a_rs2), .D_REG_S2_V(a_s2v),
      .D_ILLEGAL(a_ill), .DBG_SEL(DBG_SEL), .DBG_V(a_dbg)
   );

   decode_stage #(.XLEN(64), .NREG(16), .BYPASS(0)) dut_b (
      .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
      .I_PC(I_PC), .I_INST(I_INST), .I_VALID(I_VALID),
      .W_VALID(W_VALID), .W_REG(W_REG), .W_DATA(W_DATA),
      .D_PC(b_pc), .D_INST(b_inst), .D_VALID(b_valid), .D_OPCODE(b_op),
      .D_FUNCT3(b_f3), .D_FUNCT7(b_f7), .D_IMM(b_imm), .D_REG_D(b_rd),
      .D_REG_S1(b_rs1), .D_REG_S1_V(b_s1v), .D_REG_S2(b_rs2), .D_REG_S2_V(b_s2v),
      .D_ILLEGAL(b_ill), .DBG_SEL(DBG_SEL), .DBG_V(b_dbg)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;

   // Behavioural model state
   bit              m_valid;
   logic [31:0]     m_inst;
   logic [63:0]     m_pc;
   longint unsigned rf [2][32];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic int xl_of(int k);   return (k == 0) ? 32 : 64; endfunction
   function automatic int nreg_of(int k); return (k == 0) ? 32 : 16; endfunction
   function automatic bit byp_of(int k);  return (k == 0); endfunction

   function automatic logic [63:0] mask(logic [63:0] v, int xl);
      return (xl == 32) ? (v & 64'hFFFF_FFFF) : v;
   endfunction

   function automatic longint sx(longint v, int bits);
      longint half = longint'(1) << (bits - 1);
      return (v >= half) ? v - 2 * half : v;
   endfunction

   function automatic logic [63:0] model_imm(logic [31:0] inst, int xl);
      longint unsigned u = 64'(inst);
      longint r;
      case (int'(inst & 32'h7F))
         'h67, 'h03, 'h13, 'h73, 'h0F: r = sx(longint'(u >> 20), 12);
         'h23: r = sx(longint'(((u >> 25) << 5) | ((u >> 7) & 31)), 12);
         'h63: r = sx(longint'(((u >> 31) << 12) | (((u >> 7) & 1) << 11) |
                               (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1)), 13);
         'h37, 'h17: r = sx(longint'(u & 64'hFFFF_F000), 32);
         'h6F: r = sx(longint'(((u >> 31) << 20) | (((u >> 12) & 255) << 12) |
                               (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1)), 21);
         default: r = 0;
      endcase
      return mask(r, xl);
   endfunction

   function automatic bit model_ill(bit v, logic [31:0] inst, int nr);
      int op  = int'(inst & 32'h7F);
      int rd  = int'((inst >> 7) & 31);
      int rs1 = int'((inst >> 15) & 31);
      int rs2 = int'((inst >> 20) & 31);
      bit ur, u1, u2, legal;
      legal = 1; ur = 0; u1 = 0; u2 = 0;
      case (op)
         'h33:                         begin ur = 1; u1 = 1; u2 = 1; end
         'h67, 'h03, 'h13, 'h73, 'h0F: begin ur = 1; u1 = 1; end
         'h23, 'h63:                   begin u1 = 1; u2 = 1; end
         'h37, 'h17, 'h6F:             ur = 1;
         default:                      legal = 0;
      endcase
      if (!v) return 0;
      return !legal || (ur && rd >= nr) || (u1 && rs1 >= nr) || (u2 && rs2 >= nr);
   endfunction

   function automatic logic [63:0] model_read(int k, int idx, bit fwd);
      if (idx == 0 || idx >= nreg_of(k)) return 64'd0;
      if (fwd && byp_of(k) && W_VALID && int'(W_REG) == idx) return mask(W_DATA, xl_of(k));
      return rf[k][idx];
   endfunction

   task automatic update_model();
      if (RST) begin
         m_valid = 0; m_inst = 32'h13; m_pc = '0;
         for (int k = 0; k < 2; k++) for (int i = 0; i < 32; i++) rf[k][i] = 0;
      end else begin
         for (int k = 0; k < 2; k++)
            if (W_VALID && W_REG != 0 && int'(W_REG) < nreg_of(k))
               rf[k][W_REG] = mask(W_DATA, xl_of(k));
         if (FLUSH) begin
            m_valid = 0; m_inst = 32'h13; m_pc = I_PC;
         end else if (!STALL) begin
            m_valid = I_VALID; m_inst = I_INST; m_pc = I_PC;
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         logic [63:0] g_pc, g_imm, g_s1, g_s2, g_dbg;
         logic [31:0] g_inst, g_fld;
         logic        g_v, g_ill;
         int          xl;
         string       p;
         xl = xl_of(k);
         p  = (k == 0) ? "A" : "B";
         if (k == 0) begin
            g_pc = 64'(a_pc); g_imm = 64'(a_imm); g_s1 = 64'(a_s1v); g_s2 = 64'(a_s2v);
            g_dbg = 64'(a_dbg); g_inst = a_inst; g_v = a_valid; g_ill = a_ill;
            g_fld = {a_f7, a_rs2, a_rs1, a_f3, a_rd, a_op};
         end else begin
            g_pc = b_pc; g_imm = b_imm; g_s1 = b_s1v; g_s2 = b_s2v;
            g_dbg = b_dbg; g_inst = b_inst; g_v = b_valid; g_ill = b_ill;
            g_fld = {b_f7, b_rs2, b_rs1, b_f3, b_rd, b_op};
         end
         chk({p, " D_VALID"},    64'(g_v),   64'(m_valid));
         chk({p, " D_INST"},     64'(g_inst), 64'(m_inst));
         chk({p, " fields"},     64'(g_fld),  64'(m_inst));
         chk({p, " D_PC"},       g_pc,        mask(m_pc, xl));
         chk({p, " D_IMM"},      g_imm,       model_imm(m_inst, xl));
         chk({p, " D_ILLEGAL"},  64'(g_ill),  64'(model_ill(m_valid, m_inst, nreg_of(k))));
         chk({p, " D_REG_S1_V"}, g_s1,        model_read(k, int'((m_inst >> 15) & 31), 1));
         chk({p, " D_REG_S2_V"}, g_s2,        model_read(k, int'((m_inst >> 20) & 31), 1));
         chk({p, " DBG_V"},      g_dbg,       model_read(k, int'(DBG_SEL), 0));
      end
   endtask

   task automatic sample(); @(negedge CLK); check_all(); endtask
   task automatic edge_();  @(posedge CLK); update_model(); #1; endtask
   task automatic cyc();    sample(); edge_(); endtask

   task automatic idle();
      RST = 0; STALL = 0; FLUSH = 0; I_VALID = 0; W_VALID = 0;
      W_REG = 0; W_DATA = 0; DBG_SEL = 0; I_PC = 0; I_INST = 32'h13;
   endtask

   task automatic do_reset();
      idle(); RST = 1;
      edge_(); edge_();
   endtask

   typedef struct {
      logic [31:0] inst;
      logic [63:0] imm;    // expected at XLEN=64; XLEN=32 sees the low half
      bit          ill32;
      bit          ill16;
   } vec_t;

   vec_t vecs [12];

   initial begin
      vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0}; // ADDI x1,x0,-1 (rs2 field 31 unused)
      vecs[1]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0}; // BEQ -4 (rd field 29 unused)
      vecs[2]  = '{32'h00208A33, 64'h0,                   0, 1}; // ADD x20,x1,x2
      vecs[3]  = '{32'hFFFFFFFF, 64'h0,                   1, 1}; // opcode 1111111
      vecs[4]  = '{32'h123452B7, 64'h0000_0000_1234_5000, 0, 0}; // LUI x5
      vecs[5]  = '{32'h80000037, 64'hFFFF_FFFF_8000_0000, 0, 0}; // LUI x0,0x80000
      vecs[6]  = '{32'h0020A423, 64'h8,                   0, 0}; // SW x2,8(x1)
      vecs[7]  = '{32'h0110A423, 64'h8,                   0, 1}; // SW x17,8(x1)
      vecs[8]  = '{32'hFFFFF06F, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0}; // JAL x0,-2
      vecs[9]  = '{32'h00000F97, 64'h0,                   0, 1}; // AUIPC x31,0
      vecs[10] = '{32'h00000073, 64'h0,                   0, 0}; // ECALL
      vecs[11] = '{32'h0000000F, 64'h0,                   0, 0}; // FENCE

      do_reset();

      // Reset state, with RST still asserted
      sample();
      chk("reset D_VALID",  64'(a_valid), 64'd0);
      chk("reset D_INST",   64'(a_inst),  64'h13);
      chk("reset D_OPCODE", 64'(a_op),    64'h13);
      chk("reset D_IMM",    64'(a_imm),   64'd0);
      chk("reset D_ILLEGAL",64'(a_ill),   64'd0);
      chk("reset B D_PC",   b_pc,         64'd0);
      edge_();
      idle();

      // Vector table
      foreach (vecs[i]) begin
         idle();
         I_INST = vecs[i].inst; I_VALID = 1; I_PC = 64'(i) * 4 + 64'h1_0000_0000;
         cyc();
         idle();
         sample();
         chk($sformatf("vec%0d A imm", i), 64'(a_imm), 64'(vecs[i].imm[31:0]));
         chk($sformatf("vec%0d B imm", i), b_imm,      vecs[i].imm);
         chk($sformatf("vec%0d A ill", i), 64'(a_ill), 64'(vecs[i].ill32));
         chk($sformatf("vec%0d B ill", i), 64'(b_ill), 64'(vecs[i].ill16));
         if (i == 0) begin
            chk("addi D_VALID", 64'(a_valid), 64'd1);
            chk("addi D_REG_D", 64'(a_rd),    64'd1);
         end
         edge_();
      end

      // Forwarding: write x5 while the latched instruction reads rs1=x5
      do_reset(); idle();
      I_INST = 32'h00028093; I_VALID = 1;
      cyc();
      idle(); STALL = 1; W_VALID = 1; W_REG = 5; W_DATA = 64'h0000_0000_CAFE_0000;
      sample();
      chk("bypass A same cycle", 64'(a_s1v), 64'hCAFE_0000);
      chk("nobypass B same cycle", b_s1v, 64'd0);
      edge_();
      W_VALID = 0;
      sample();
      chk("nobypass B next cycle", b_s1v, 64'hCAFE_0000);
      edge_();

      // Writes to x0 are ignored, including the forwarding path
      idle(); I_INST = 32'hFFF00093; I_VALID = 1;
      cyc();
      idle(); STALL = 1; W_VALID = 1; W_REG = 0; W_DATA = 64'h1234;
      sample();
      chk("x0 no bypass", 64'(a_s1v), 64'd0);
      edge_();
      W_VALID = 0;
      sample();
      chk("x0 DBG", 64'(a_dbg), 64'd0);
      chk("x0 rs1", 64'(a_s1v), 64'd0);
      edge_();

      // Out-of-range write is ignored by the 16-entry instance only
      idle(); W_VALID = 1; W_REG = 20; W_DATA = 64'h5555_AAAA_0000_1111;
      cyc();
      idle(); DBG_SEL = 20;
      sample();
      chk("x20 A DBG", 64'(a_dbg), 64'h0000_1111);
      chk("x20 B DBG", b_dbg,      64'd0);
      edge_();

      // Stall for three cycles with changing fetch, then stall+flush
      idle(); I_INST = 32'h0020A423; I_VALID = 1;
      cyc();
      for (int i = 0; i < 3; i++) begin
         STALL = 1; I_INST = $urandom; I_VALID = 1;
         cyc();
         sample();
         chk($sformatf("stall%0d D_INST", i), 64'(a_inst), 64'h0020A423);
         edge_();
      end
      STALL = 1; FLUSH = 1; I_INST = 32'h00208A33;
      cyc();
      idle();
      sample();
      chk("flush D_VALID", 64'(a_valid), 64'd0);
      chk("flush D_INST",  64'(a_inst),  64'h13);
      edge_();

      // Reset asserted mid-stall releases empty
      idle(); I_INST = 32'h123452B7; I_VALID = 1; I_PC = 64'h40;
      cyc();
      STALL = 1; RST = 1;
      cyc();
      RST = 0;
      sample();
      chk("rst-stall D_VALID", 64'(a_valid), 64'd0);
      chk("rst-stall D_INST",  64'(a_inst),  64'h13);
      chk("rst-stall D_PC",    64'(a_pc),    64'd0);
      edge_();

      // Randomized traffic against the model
      begin
         logic [6:0] ops [11];
         ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
         for (int n = 0; n < 400; n++) begin
            RST     = ($urandom_range(0, 63) == 0);
            STALL   = ($urandom_range(0, 3) == 0);
            FLUSH   = ($urandom_range(0, 7) == 0);
            I_VALID = ($urandom_range(0, 4) != 0);
            I_PC    = {$urandom, $urandom};
            I_INST  = $urandom;
            if ($urandom_range(0, 3) != 0) I_INST[6:0] = ops[$urandom_range(0, 10)];
            W_VALID = $urandom_range(0, 1) == 1;
            W_REG   = 5'($urandom_range(0, 31));
            W_DATA  = {$urandom, $urandom};
            DBG_SEL = 5'($urandom_range(0, 31));
            cyc();
         end
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width of PC, immediates and register values (32 or 64).
REQ-002 Parameter NREG, default 32: architectural register count (32 for RV32I, 16 for RV32E).
REQ-003 Parameter BYPASS, default 1: 1 enables write-back-to-read forwarding; 0 disables it.
REQ-004 Ports; clock and reset first:
- CLK  in  1  clock; one clock domain only.
- RST  in  1  reset, synchronous, active-high.
- STALL  in  1  hold the pipeline register.
- FLUSH  in  1  kill the instruction being captured.
- I_PC  in  XLEN  fetch PC.
- I_INST  in  32  fetch instruction.
- I_VALID  in  1  fetch valid.
- W_VALID  in  1  write-back enable.
- W_REG  in  5  write-back destination index.
- W_DATA  in  XLEN  write-back value.
- D_PC  out  XLEN  latched PC.
- D_INST  out  32  latched instruction.
- D_VALID  out  1  latched valid.
- D_OPCODE  out  7  inst[6:0].
- D_FUNCT3  out  3  inst[14:12].
- D_FUNCT7  out  7  inst[31:25].
- D_IMM  out  XLEN  sign-extended immediate.
- D_REG_D  out  5  inst[11:7].
- D_REG_S1  out  5  inst[19:15].
- D_REG_S1_V  out  XLEN  rs1 value.
- D_REG_S2  out  5  inst[24:20].
- D_REG_S2_V  out  XLEN  rs2 value.
- D_ILLEGAL  out  1  unsupported opcode or register index >= NREG.
- DBG_SEL  in  5  debug register select.
- DBG_V  out  XLEN  value of register DBG_SEL; 0 for index 0 or an index >= NREG.

Function
REQ-005 The pipeline register (pc, inst, valid) shall capture I_* at each rising CLK edge when STALL=0 and FLUSH=0.
REQ-006 When STALL=1 and FLUSH=0, the pipeline register shall hold its value.
REQ-007 When FLUSH=1, the next valid shall be 0 regardless of STALL; inst shall load 32'h00000013 (NOP); pc shall load I_PC.
REQ-008 The decode fields shall be combinational from the latched inst, with zero cycles of latency after the register.
REQ-009 D_IMM shall be sign-extended from inst[31] to XLEN, by format:
- I (opcodes 1100111, 0000011, 0010011, 1110011, 0001111): inst[31:20].
- S (0100011): {inst[31:25], inst[11:7]}.
- B (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U (0110111, 0010111): {inst[31:12], 12'b0}.
- J (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- R (0110011) and all other opcodes: 0.
REQ-010 D_ILLEGAL shall be 1 when D_VALID=1 and either condition holds:
- The opcode is not in REQ-009's list.
- Any used index (rd, rs1 or rs2, per format) is >= NREG.
REQ-011 D_ILLEGAL shall be 0 whenever D_VALID=0.
REQ-012 The register file shall hold NREG-1 writable XLEN-bit entries; x0 shall always read 0.
REQ-013 Register file writes:
- A write occurs at a rising edge when W_VALID=1 and W_REG != 0 and W_REG < NREG.
- Writes with W_REG = 0 or W_REG >= NREG shall be ignored.
- STALL and FLUSH shall not block writes.
REQ-014 Read ports:
- D_REG_S1_V / D_REG_S2_V shall return the stored value.
- With BYPASS=1, they shall return W_DATA in the same cycle when W_VALID=1 and W_REG equals the source index (nonzero, < NREG).
REQ-015 Index 0 or an index >= NREG shall read as 0 on all read ports.
REQ-016 Simultaneous write-back and capture shall both complete in the same edge; neither takes priority.

Reset
REQ-017 While RST=1 at a rising edge, the following shall reset:
- valid <= 0.
- inst <= 32'h00000013.
- pc <= 0.
- All register file entries <= 0.
REQ-018 RST shall override STALL, FLUSH and W_VALID.
REQ-019 Outputs after reset:
- D_VALID=0, D_INST=32'h13, D_OPCODE=7'h13.
- D_IMM=0, D_ILLEGAL=0.
- All register values = 0.
REQ-020 A reset asserted mid-stall shall release into the empty state; the held instruction is discarded.

Structure
REQ-021 A shared package shall hold the following; the ALU and execute stages shall import it:
- Opcode constants.
- The immediate-format enumeration.
- The NOP encoding.
REQ-022 The register file shall be a separate sub-module named regfile, with parameters XLEN and NREG, one write port and three read ports (rs1, rs2, debug).

Verification
REQ-023 Reset, then ADDI x1,x0,-1 (32'hFFF00093) -> next cycle:
- D_VALID=1.
- D_IMM=32'hFFFFFFFF.
- D_REG_D=1.
REQ-024 W_VALID=1, W_REG=5, W_DATA=32'hCAFE0000 while the latched inst reads rs1=x5 -> D_REG_S1_V=32'hCAFE0000 in the same cycle when BYPASS=1, and one cycle later when BYPASS=0.
REQ-025 W_REG=0, W_DATA=32'h1234 -> DBG_SEL=0 reads 0, and an instruction reading x0 sees 0.
REQ-026 STALL for 3 cycles with I_INST changing each cycle -> D_INST is unchanged throughout; with STALL=1 and FLUSH=1 together -> next D_VALID=0 and D_INST=32'h13.
REQ-027 NREG=16, ADD x20,x1,x2 -> D_ILLEGAL=1; opcode 7'b1111111 -> D_ILLEGAL=1 and D_IMM=0.
REQ-028 BEQ with imm=-4 (32'hFE000EE3) -> D_IMM=32'hFFFFFFFC; with XLEN=64 -> D_IMM=64'hFFFFFFFFFFFFFFFC.
